// File: rtl/paquete_ciscud.sv
// Shared definitions for the ciscud memory path: widths, address limit,
// sequencer states and requester identifiers.
package paquete_ciscud;

  localparam int unsigned ANCHO_DATO = 16;
  localparam int unsigned ANCHO_DIR  = 16;
  localparam logic [15:0] DIR_MAX    = 16'h000F;

  typedef enum logic [2:0] {
    LIBRE   = 3'd0,
    EMITIR  = 3'd1,
    ESPERA  = 3'd2,
    FIN     = 3'd3,
    RECHAZO = 3'd4
  } estado_t;

  localparam logic REQ_BUSQUEDA = 1'b0;
  localparam logic REQ_DATOS    = 1'b1;

endpackage

// File: rtl/Memoria16X16Bits.sv
// 16x16 core memory: registered read, write on the clock edge, boot words
// at addresses 0 and 1 restored every cycle, output released when idle.
module Memoria16X16Bits (
  input  logic        Reloj,
  input  logic [3:0]  Direccion,
  input  logic [15:0] Entrada,
  input  logic        HabilitarEscritura,
  input  logic        HabilitarSalida,
  output logic [15:0] Salida
);

  logic [15:0] celdas_q [16];
  logic [15:0] leido_q;
  logic        salida_q;

  always_ff @(posedge Reloj) begin
    if (HabilitarEscritura) celdas_q[Direccion] <= Entrada;
    celdas_q[0] <= 16'h4000;
    celdas_q[1] <= 16'h0017;
    leido_q     <= celdas_q[Direccion];
    salida_q    <= HabilitarSalida;
  end

  assign Salida = salida_q ? leido_q : 'z;

endmodule

// File: rtl/selector_turno.sv
// Two-input round-robin grant: on a tie the priority holder wins, and on
// advance the priority moves to the requester that was not just served.
module selector_turno
  import paquete_ciscud::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] pedir_i,
  input  logic       avanzar_i,
  input  logic       servido_i,
  output logic       concedido_o,
  output logic       hay_pedido_o
);

  logic prioridad_q, prioridad_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) prioridad_q <= REQ_BUSQUEDA;
    else       prioridad_q <= prioridad_d;
  end

  always_comb begin
    prioridad_d = prioridad_q;
    if (avanzar_i) prioridad_d = ~servido_i;
  end

  always_comb begin
    hay_pedido_o = |pedir_i;
    if (&pedir_i)        concedido_o = prioridad_q;
    else if (pedir_i[1]) concedido_o = REQ_DATOS;
    else                 concedido_o = REQ_BUSQUEDA;
  end

endmodule

// File: rtl/arbitro_memoria.sv
// Arbiter and sequencer between instruction fetch and the execute unit for
// the shared 16x16 memory; every output, memory pins included, is a register.
module arbitro_memoria
  import paquete_ciscud::*;
#(
  parameter int unsigned          ANCHO_DATO = paquete_ciscud::ANCHO_DATO,
  parameter int unsigned          ANCHO_DIR  = paquete_ciscud::ANCHO_DIR,
  parameter logic [ANCHO_DIR-1:0] DIR_MAX    = paquete_ciscud::DIR_MAX
) (
  input  logic                  Reloj,
  input  logic                  Reiniciar,
  input  logic                  Pedir0,
  input  logic [ANCHO_DIR-1:0]  Dir0,
  output logic                  Listo0,
  output logic [ANCHO_DATO-1:0] Dato0,
  output logic                  Error0,
  input  logic                  Pedir1,
  input  logic                  Escribir1,
  input  logic [ANCHO_DIR-1:0]  Dir1,
  input  logic [ANCHO_DATO-1:0] DatoEsc1,
  output logic                  Listo1,
  output logic [ANCHO_DATO-1:0] Dato1,
  output logic                  Error1,
  output logic [ANCHO_DIR-1:0]  MemDireccion,
  output logic [ANCHO_DATO-1:0] MemEntrada,
  output logic                  MemHabilitarEscritura,
  output logic                  MemHabilitarSalida,
  input  logic [ANCHO_DATO-1:0] MemSalida,
  output logic                  Ocupado
);

  estado_t estado_q, estado_d;

  logic                  concedido, hay_pedido, avanzar;
  logic [ANCHO_DIR-1:0]  dir_sel;
  logic                  dir_valida, escritura_sel;

  logic                  turno_q, turno_d;
  logic [ANCHO_DIR-1:0]  mem_dir_q, mem_dir_d;
  logic [ANCHO_DATO-1:0] mem_ent_q, mem_ent_d;
  logic                  mem_we_q, mem_we_d, mem_oe_q, mem_oe_d;
  logic                  listo0_q, listo0_d, listo1_q, listo1_d;
  logic                  error0_q, error0_d, error1_q, error1_d;
  logic [ANCHO_DATO-1:0] dato0_q, dato0_d, dato1_q, dato1_d;
  logic                  ocupado_q, ocupado_d;

  selector_turno u_selector (
    .clk_i        (Reloj),
    .rst_i        (Reiniciar),
    .pedir_i      ({Pedir1, Pedir0}),
    .avanzar_i    (avanzar),
    .servido_i    (turno_q),
    .concedido_o  (concedido),
    .hay_pedido_o (hay_pedido)
  );

  assign dir_sel       = (concedido == REQ_DATOS) ? Dir1 : Dir0;
  assign dir_valida    = (dir_sel <= DIR_MAX);
  assign escritura_sel = (concedido == REQ_DATOS) && Escribir1;

  always_ff @(posedge Reloj or posedge Reiniciar) begin
    if (Reiniciar) estado_q <= LIBRE;
    else           estado_q <= estado_d;
  end

  always_comb begin
    estado_d = estado_q;
    unique case (estado_q)
      LIBRE:        if (hay_pedido) estado_d = dir_valida ? EMITIR : RECHAZO;
      EMITIR:       estado_d = mem_we_q ? FIN : ESPERA;
      ESPERA:       estado_d = FIN;
      FIN, RECHAZO: estado_d = LIBRE;
      default:      estado_d = LIBRE;
    endcase
  end

  // Listo/Error are raised on the edge that enters FIN or RECHAZO so they
  // are visible for exactly the one cycle spent there.
  always_comb begin
    turno_d   = turno_q;
    mem_dir_d = mem_dir_q;
    mem_ent_d = mem_ent_q;
    mem_we_d  = 1'b0;
    mem_oe_d  = 1'b0;
    listo0_d  = 1'b0;
    listo1_d  = 1'b0;
    error0_d  = 1'b0;
    error1_d  = 1'b0;
    dato0_d   = dato0_q;
    dato1_d   = dato1_q;
    avanzar   = 1'b0;
    ocupado_d = (estado_d != LIBRE);
    unique case (estado_q)
      LIBRE: begin
        if (hay_pedido) begin
          turno_d = concedido;
          if (dir_valida) begin
            mem_dir_d = dir_sel;
            mem_ent_d = escritura_sel ? DatoEsc1 : '0;
            mem_we_d  = escritura_sel;
            mem_oe_d  = ~escritura_sel;
          end else if (concedido == REQ_DATOS) begin
            listo1_d = 1'b1;
            error1_d = 1'b1;
          end else begin
            listo0_d = 1'b1;
            error0_d = 1'b1;
          end
        end
      end
      EMITIR: begin
        if (mem_we_q) begin
          if (turno_q == REQ_DATOS) listo1_d = 1'b1;
          else                      listo0_d = 1'b1;
        end
      end
      ESPERA: begin
        if (turno_q == REQ_DATOS) begin
          dato1_d  = MemSalida;
          listo1_d = 1'b1;
        end else begin
          dato0_d  = MemSalida;
          listo0_d = 1'b1;
        end
      end
      FIN, RECHAZO: avanzar = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge Reloj or posedge Reiniciar) begin
    if (Reiniciar) begin
      turno_q   <= REQ_BUSQUEDA;
      mem_dir_q <= '0;
      mem_ent_q <= '0;
      mem_we_q  <= 1'b0;
      mem_oe_q  <= 1'b0;
      listo0_q  <= 1'b0;
      listo1_q  <= 1'b0;
      error0_q  <= 1'b0;
      error1_q  <= 1'b0;
      dato0_q   <= '0;
      dato1_q   <= '0;
      ocupado_q <= 1'b0;
    end else begin
      turno_q   <= turno_d;
      mem_dir_q <= mem_dir_d;
      mem_ent_q <= mem_ent_d;
      mem_we_q  <= mem_we_d;
      mem_oe_q  <= mem_oe_d;
      listo0_q  <= listo0_d;
      listo1_q  <= listo1_d;
      error0_q  <= error0_d;
      error1_q  <= error1_d;
      dato0_q   <= dato0_d;
      dato1_q   <= dato1_d;
      ocupado_q <= ocupado_d;
    end
  end

  assign Listo0                = listo0_q;
  assign Dato0                 = dato0_q;
  assign Error0                = error0_q;
  assign Listo1                = listo1_q;
  assign Dato1                 = dato1_q;
  assign Error1                = error1_q;
  assign MemDireccion          = mem_dir_q;
  assign MemEntrada            = mem_ent_q;
  assign MemHabilitarEscritura = mem_we_q;
  assign MemHabilitarSalida    = mem_oe_q;
  assign Ocupado               = ocupado_q;

endmodule

// File: tb/tb_arbitro_memoria.sv
// Bench for arbitro_memoria driving the real 16x16 memory; expectations come
// from a transaction-level model of memory contents, port data and priority.
module tb_arbitro_memoria;

  logic        Reloj = 1'b0;
  logic        Reiniciar;
  logic        Pedir0, Pedir1, Escribir1;
  logic [15:0] Dir0, Dir1, DatoEsc1;
  logic        Listo0, Error0, Listo1, Error1;
  logic [15:0] Dato0, Dato1;
  logic [15:0] MemDireccion, MemEntrada, MemSalida;
  logic        MemHabilitarEscritura, MemHabilitarSalida, Ocupado;

  always #5 Reloj = ~Reloj;

  arbitro_memoria #(.ANCHO_DATO(16), .ANCHO_DIR(16), .DIR_MAX(16'h000F)) dut (
    .Reloj(Reloj), .Reiniciar(Reiniciar),
    .Pedir0(Pedir0), .Dir0(Dir0), .Listo0(Listo0), .Dato0(Dato0), .Error0(Error0),
    .Pedir1(Pedir1), .Escribir1(Escribir1), .Dir1(Dir1), .DatoEsc1(DatoEsc1),
    .Listo1(Listo1), .Dato1(Dato1), .Error1(Error1),
    .MemDireccion(MemDireccion), .MemEntrada(MemEntrada),
    .MemHabilitarEscritura(MemHabilitarEscritura),
    .MemHabilitarSalida(MemHabilitarSalida),
    .MemSalida(MemSalida), .Ocupado(Ocupado)
  );

  Memoria16X16Bits u_mem (
    .Reloj(Reloj), .Direccion(MemDireccion[3:0]), .Entrada(MemEntrada),
    .HabilitarEscritura(MemHabilitarEscritura),
    .HabilitarSalida(MemHabilitarSalida), .Salida(MemSalida)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] mem_m [16];
  logic [15:0] dato_m [2];
  logic        prio_m;

  typedef struct {
    logic        p;
    logic [15:0] dato;
    logic        err;
  } esperado_t;
  esperado_t cola[$];

  typedef struct {
    logic        p;
    logic        w;
    logic [15:0] d;
    logic [15:0] de;
    logic [15:0] exp_dato;
    logic        exp_err;
    int          exp_lat;
  } vector_t;
  vector_t tabla[9];

  task automatic chk(input string nombre, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nombre, got, exp);
    end
  endtask

  task automatic modelo(input logic p, input logic w, input logic [15:0] d,
                        input logic [15:0] de, output logic [15:0] dato, output logic err);
    if (d > 16'h000F) err = 1'b1;
    else begin
      err = 1'b0;
      if (p && w) begin
        if (d > 16'd1) mem_m[d[3:0]] = de;
      end else dato_m[p] = mem_m[d[3:0]];
    end
    dato   = dato_m[p];
    prio_m = !p;
  endtask

  task automatic reiniciar();
    Reiniciar = 1'b1;
    Pedir0 = 1'b0; Pedir1 = 1'b0; Escribir1 = 1'b0;
    Dir0 = '0; Dir1 = '0; DatoEsc1 = '0;
    @(posedge Reloj); #1;
    Reiniciar = 1'b0;
    prio_m = 1'b0; dato_m[0] = '0; dato_m[1] = '0;
    @(posedge Reloj); #1;
  endtask

  task automatic esperar_libre();
    for (int i = 0; i < 12; i++) begin
      if (!Ocupado) return;
      @(posedge Reloj); #1;
    end
    chk("libre_timeout", Ocupado, 0);
  endtask

  task automatic transaccion(input logic p, input logic w, input logic [15:0] d,
                             input logic [15:0] de, output int lat, output logic [15:0] dato,
                             output logic err, output logic en_vista, output logic pulso_unico);
    esperar_libre();
    if (p) begin Pedir1 = 1'b1; Escribir1 = w; Dir1 = d; DatoEsc1 = de; end
    else   begin Pedir0 = 1'b1; Dir0 = d; end
    lat = -1; en_vista = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge Reloj); #1;
      if (MemHabilitarEscritura || MemHabilitarSalida) en_vista = 1'b1;
      if (p ? Listo1 : Listo0) begin lat = i; break; end
    end
    dato = p ? Dato1 : Dato0;
    err  = p ? Error1 : Error0;
    Pedir0 = 1'b0; Pedir1 = 1'b0; Escribir1 = 1'b0;
    @(posedge Reloj); #1;
    pulso_unico = !(p ? Listo1 : Listo0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, k, ultimo, racha;
    logic [15:0] dato, ed;
    logic        err, ee, env, uni;
    logic        usa [2];
    logic        pw [2];
    logic [15:0] pd [2], pde [2];
    esperado_t   e;

    mem_m[0] = 16'h4000; mem_m[1] = 16'h0017;
    for (int i = 2; i < 16; i++) mem_m[i] = '0;

    tabla[0] = '{1'b0, 1'b0, 16'h0001, 16'h0000, 16'h0017, 1'b0, 3};
    tabla[1] = '{1'b1, 1'b1, 16'h0005, 16'hBEEF, 16'h0000, 1'b0, 2};
    tabla[2] = '{1'b0, 1'b0, 16'h0005, 16'h0000, 16'hBEEF, 1'b0, 3};
    tabla[3] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'h0000, 1'b1, 1};
    tabla[4] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h4000, 1'b0, 3};
    tabla[5] = '{1'b1, 1'b1, 16'h0007, 16'h1234, 16'h0000, 1'b0, 2};
    tabla[6] = '{1'b1, 1'b0, 16'h0007, 16'h0000, 16'h1234, 1'b0, 3};
    tabla[7] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h4000, 1'b1, 1};
    tabla[8] = '{1'b1, 1'b1, 16'h0100, 16'h5555, 16'h1234, 1'b1, 1};

    reiniciar();
    chk("reset_salidas", |{Listo0, Dato0, Error0, Listo1, Dato1, Error1, MemDireccion,
        MemEntrada, MemHabilitarEscritura, MemHabilitarSalida, Ocupado}, 0);

    foreach (tabla[i]) begin
      modelo(tabla[i].p, tabla[i].w, tabla[i].d, tabla[i].de, ed, ee);
      transaccion(tabla[i].p, tabla[i].w, tabla[i].d, tabla[i].de, lat, dato, err, env, uni);
      chk($sformatf("tabla%0d_latencia", i), lat, tabla[i].exp_lat);
      chk($sformatf("tabla%0d_dato", i), dato, tabla[i].exp_dato);
      chk($sformatf("tabla%0d_error", i), err, tabla[i].exp_err);
      chk($sformatf("tabla%0d_habilitacion", i), env, tabla[i].exp_err ? 0 : 1);
      chk($sformatf("tabla%0d_pulso", i), uni, 1);
    end

    // Give every writable cell a known value before random traffic
    for (int a = 2; a < 16; a++) begin
      pde[0] = 16'($urandom);
      modelo(1'b1, 1'b1, 16'(a), pde[0], ed, ee);
      transaccion(1'b1, 1'b1, 16'(a), pde[0], lat, dato, err, env, uni);
      chk("init_latencia", lat, 2);
    end

    for (int r = 0; r < 40; r++) begin
      usa[0] = 1'($urandom_range(0, 1));
      usa[1] = 1'($urandom_range(0, 1));
      if (!usa[0] && !usa[1]) usa[r % 2] = 1'b1;
      for (int p = 0; p < 2; p++) begin
        pw[p] = (p == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        if ($urandom_range(0, 3) == 0) pd[p] = 16'(16'h0010 + $urandom_range(0, 16'hFFEF));
        else                           pd[p] = 16'($urandom_range(0, 15));
        if (pw[p] && pd[p] <= 16'd1) pd[p] = pd[p] + 16'd2;
        pde[p] = 16'($urandom);
      end
      cola.delete();
      if (usa[0] && usa[1]) begin
        for (int n = 0; n < 2; n++) begin
          e.p = prio_m;
          modelo(e.p, pw[e.p], pd[e.p], pde[e.p], e.dato, e.err);
          cola.push_back(e);
        end
      end else begin
        e.p = usa[1];
        modelo(e.p, pw[e.p], pd[e.p], pde[e.p], e.dato, e.err);
        cola.push_back(e);
      end
      esperar_libre();
      Pedir0 = usa[0]; Dir0 = pd[0];
      Pedir1 = usa[1]; Escribir1 = pw[1]; Dir1 = pd[1]; DatoEsc1 = pde[1];
      for (int i = 0; i < 24 && cola.size() > 0; i++) begin
        @(posedge Reloj); #1;
        if (Listo0 || Listo1) begin
          e = cola.pop_front();
          chk("azar_orden", {Listo1, Listo0}, e.p ? 2'b10 : 2'b01);
          chk("azar_dato", e.p ? Dato1 : Dato0, e.dato);
          chk("azar_error", e.p ? Error1 : Error0, e.err);
          if (e.p) begin Pedir1 = 1'b0; Escribir1 = 1'b0; end
          else Pedir0 = 1'b0;
        end
      end
      if (cola.size() != 0) chk("azar_timeout", cola.size(), 0);
      Pedir0 = 1'b0; Pedir1 = 1'b0; Escribir1 = 1'b0;
    end

    // Asynchronous reset while a write sits in EMITIR: the write must not land
    esperar_libre();
    Pedir1 = 1'b1; Escribir1 = 1'b1; Dir1 = 16'h0007; DatoEsc1 = ~mem_m[7];
    @(posedge Reloj); #1;
    chk("emitir_escritura", MemHabilitarEscritura, 1);
    #2 Reiniciar = 1'b1;
    #1 chk("reinicio_async", |{Listo0, Dato0, Error0, Listo1, Dato1, Error1, MemDireccion,
        MemEntrada, MemHabilitarEscritura, MemHabilitarSalida, Ocupado}, 0);
    Pedir1 = 1'b0; Escribir1 = 1'b0;
    #1 Reiniciar = 1'b0;
    prio_m = 1'b0; dato_m[0] = '0; dato_m[1] = '0;
    modelo(1'b0, 1'b0, 16'h0007, 16'h0000, ed, ee);
    transaccion(1'b0, 1'b0, 16'h0007, 16'h0000, lat, dato, err, env, uni);
    chk("abortada_dato", dato, ed);

    // Both requesters held from the same edge after reset
    reiniciar();
    k = 0; ultimo = 0; racha = 0;
    Pedir0 = 1'b1; Dir0 = 16'h0002;
    Pedir1 = 1'b1; Escribir1 = 1'b0; Dir1 = 16'h0003;
    for (int i = 1; i <= 40 && k < 4; i++) begin
      @(posedge Reloj); #1;
      if (!Ocupado) racha++;
      else if (racha > 0) begin
        chk("libre_un_ciclo", racha, 1);
        racha = 0;
      end
      if (Listo0 || Listo1) begin
        e.p = prio_m;
        modelo(e.p, 1'b0, e.p ? 16'h0003 : 16'h0002, 16'h0000, e.dato, e.err);
        chk("alterna_orden", {Listo1, Listo0}, e.p ? 2'b10 : 2'b01);
        chk("alterna_dato", e.p ? Dato1 : Dato0, e.dato);
        if (k > 0) chk("alterna_periodo", i - ultimo, 4);
        ultimo = i;
        k++;
      end
    end
    Pedir0 = 1'b0; Pedir1 = 1'b0;
    chk("alterna_cuenta", k, 4);

    // Pedir held through FIN: no grant in FIN, a fresh one in the next LIBRE
    esperar_libre();
    Pedir0 = 1'b1; Dir0 = 16'h0000;
    lat = -1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge Reloj); #1;
      if (Listo0) begin lat = i; break; end
    end
    modelo(1'b0, 1'b0, 16'h0000, 16'h0000, ed, ee);
    chk("sostenido_latencia", lat, 3);
    chk("sostenido_dato", Dato0, ed);
    @(posedge Reloj); #1;
    chk("sostenido_libre", {Ocupado, Listo0}, 2'b00);
    @(posedge Reloj); #1;
    chk("sostenido_reconcesion", MemHabilitarSalida, 1);
    Pedir0 = 1'b0;
    modelo(1'b0, 1'b0, 16'h0000, 16'h0000, ed, ee);
    lat = -1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge Reloj); #1;
      if (Listo0) begin lat = i; break; end
    end
    chk("abandono_completa", lat, 2);
    chk("abandono_dato", Dato0, ed);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arbitro_memoria.md
Name: arbitro_memoria

Overview:
- Two-requester arbiter and sequencer for the shared 16x16-bit memory of the ciscud core.
- Requester 0 is instruction fetch (read-only); requester 1 is the data/execute unit (read or write).
- Owns the memory's Direccion/Entrada/HabilitarEscritura/HabilitarSalida pins and captures its registered Salida.
- Round-robin arbitration, per-requester req/ack handshake, and rejection of addresses outside the physical memory.

Parameters:
- ANCHO_DATO, 16, data width.
- ANCHO_DIR, 16, address bus width.
- DIR_MAX, 16'h000F, highest physically present address; requests above it are rejected.

Ports:
- Reloj  input  1  clock; all state changes on the rising edge.
- Reiniciar  input  1  reset; asynchronous, active-high.
- Pedir0  input  1  fetch request; held high until Listo0.
- Dir0  input  16  fetch address.
- Listo0  output  1  one-cycle completion pulse to fetch.
- Dato0  output  16  read data to fetch; holds until the next fetch completion.
- Error0  output  1  valid with Listo0: address out of range.
- Pedir1  input  1  data request; held until Listo1.
- Escribir1  input  1  1 = write, 0 = read; stable while Pedir1 is high.
- Dir1  input  16  data address.
- DatoEsc1  input  16  write data.
- Listo1, Dato1, Error1  output  1/16/1  same semantics as port 0, for requester 1.
- MemDireccion  output  16  to memory Direccion.
- MemEntrada  output  16  to memory Entrada.
- MemHabilitarEscritura  output  1  to memory HabilitarEscritura.
- MemHabilitarSalida  output  1  to memory HabilitarSalida.
- MemSalida  input  16  from memory Salida; tri-stated by the memory when idle.
- Ocupado  output  1  high in every state except LIBRE.

Behaviour:
- Reset (asynchronous): state=LIBRE, priority=0, all outputs 0 (Dato0/Dato1=16'h0000). The memory enables drop immediately, so an access in flight is aborted (a pending write is not committed). Requesters must re-issue.
- All outputs are registered.
- States: LIBRE, EMITIR, ESPERA, FIN, RECHAZO.
- LIBRE:
  - Samples Pedir0/Pedir1.
  - Both high: grant to the requester named by priority. One high: grant to it.
  - Granted address > DIR_MAX: go to RECHAZO, with no memory enable.
  - Otherwise go to EMITIR, registering MemDireccion, MemEntrada (DatoEsc1 for a write, else 0), and exactly one enable (write iff requester 1 and Escribir1).
- EMITIR, one cycle:
  - Enables are high. The memory acts on the closing edge.
  - Write: next state FIN. Read: next state ESPERA.
  - Enables are cleared on the closing edge.
- ESPERA, one cycle: MemSalida is valid; latch it into Dato of the granted port on the closing edge; go to FIN.
- FIN, one cycle: Listo of the granted port = 1, Error = 0. Priority toggles to the other requester. Then LIBRE.
- RECHAZO, one cycle: Listo = 1, Error = 1, Dato unchanged, priority toggles. Then LIBRE.
- FIN and RECHAZO ignore requests. This lets the requester drop Pedir on the edge that ends Listo, with no double grant.
- Latency from the grant edge to the Listo pulse: read 3 cycles, write 2 cycles, rejected 1 cycle.
- Throughput: back-to-back reads by alternating requesters complete every 4 cycles.
- MemSalida is sampled only in ESPERA. Its high-Z value in other states is never latched.
- Pedir deasserted mid-transaction (protocol violation): the transaction still completes and Listo still pulses.
- Address bits above bit 3 must be zero for acceptance. With ANCHO_DIR=16 and DIR_MAX=15, 16'h0010 and above are rejected.
- The memory rewrites addresses 0 and 1 with its boot words (16'h4000, 16'h0017) every cycle, so writes there do not persist. The arbiter does not special-case this; the bench must not check write-back there.

Decomposition:
- Shared package paquete_ciscud holds:
  - state encoding constants: LIBRE=3'd0, EMITIR=3'd1, ESPERA=3'd2, FIN=3'd3, RECHAZO=3'd4
  - requester ids: REQ_BUSQUEDA=0, REQ_DATOS=1
  - ANCHO_DATO, ANCHO_DIR, DIR_MAX
- One natural sub-module: selector_turno, a two-input round-robin grant with a priority register and a toggle input. The FSM and datapath registers stay in arbitro_memoria.
- Bench instantiates arbitro_memoria with Memoria16X16Bits.

Test Plan:
- Reset, then Pedir0=1 with Dir0=16'h0001 -> Listo0 pulses 3 cycles after the grant edge, Dato0=16'h0017, Error0=0.
- Pedir1=1, Escribir1=1, Dir1=16'h0005, DatoEsc1=16'hBEEF -> Listo1 after 2 cycles. Then a read of 16'h0005 by port 0 -> Dato0=16'hBEEF.
- Pedir0 and Pedir1 rise on the same edge after reset -> port 0 is served first and port 1 next. Both held continuously -> grants alternate 0,1,0,1. Ocupado drops to 0 for exactly one LIBRE cycle between transactions.
- Pedir1=1, Dir1=16'h0010 -> one-cycle RECHAZO, Listo1=1 with Error1=1, Dato1 unchanged, MemHabilitarEscritura and MemHabilitarSalida never high.
- Reiniciar pulsed asynchronously during EMITIR of a write to 16'h0007 -> outputs zero immediately, and a later read of 16'h0007 returns the old value.
- Read of 16'h0000 -> Dato=16'h4000. Pedir held high after Listo -> no new grant occurs during FIN.
